// File: rtl/spi_pwm_host_master_if.sv
// Command/response bundle between a host and spi_pwm_host_master.
// The "master" modport is the side that issues commands; the "slave"
// modport is the SPI master block that executes them.
interface spi_pwm_host_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/spi_pwm_host_master.sv
// spi_pwm_host_master: turns single-register write/read commands into 16-bit
// SPI frames for the 7-channel PWM driver. SCLK half-phases last HALF_PERIOD
// clk cycles so an oversampling slave running on its own clock sees every
// edge. Read data arrives LSB first during the second byte of the frame.
module spi_pwm_host_master #(
    parameter int HALF_PERIOD = 8,
    parameter int HP_W        = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_pwm_host_master_if.slave cmd,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 mosi,
    input  logic                 miso
);

    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          r_state;
    logic [HP_W-1:0] r_hp;          // position inside the current half-phase
    logic [4:0]      r_bit;         // number of SCLK rises issued so far
    logic [14:0]     r_sr;          // frame bits still to be put on mosi
    logic            r_write;       // latched command type
    logic [7:0]      r_wdata;       // latched write level, echoed on completion
    logic [7:0]      r_rx;          // read level being assembled LSB first
    logic            r_sclk;
    logic            r_cs_n;
    logic            r_mosi;
    logic            r_ready;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic [1:0]      r_miso_sync;

    logic            w_accept;
    logic            w_phase_end;
    logic            w_capture;
    logic            w_miso_s;
    logic [15:0]     w_frame;

    // Frame layout: {rw, 4'b0000, addr, data}; reads send a zero data byte.
    assign w_frame     = {cmd.cmd_write, 4'b0000, cmd.cmd_addr,
                          cmd.cmd_write ? cmd.cmd_data : 8'h00};
    assign w_accept    = cmd.cmd_valid && r_ready;
    assign w_phase_end = (r_hp == HP_LAST);
    // Rises 9..16 (r_bit 8..15 before the increment) carry the read level.
    assign w_capture   = (r_bit[4:3] == 2'b01);
    assign w_miso_s    = r_miso_sync[1];

    assign sclk          = r_sclk;
    assign cs_n          = r_cs_n;
    assign mosi          = r_mosi;
    assign cmd.cmd_ready = r_ready;
    assign cmd.busy      = !r_ready;
    assign cmd.rsp_valid = r_rsp_valid;
    assign cmd.rsp_data  = r_rsp_data;

    // Two-flop synchroniser for the asynchronous miso line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_miso_sync <= 2'b00;
        end else begin
            r_miso_sync <= {r_miso_sync[0], miso};
        end
    end

    // Frame sequencer: SETUP, 16 SCLK periods, HOLD for the slave's final
    // falling-edge commit, then a cs_n-high GAP before accepting again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hp        <= '0;
            r_bit       <= '0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_SETUP;
                        r_ready <= 1'b0;
                        r_cs_n  <= 1'b0;
                        r_mosi  <= w_frame[15];
                        r_sr    <= w_frame[14:0];
                        r_write <= cmd.cmd_write;
                        r_wdata <= cmd.cmd_data;
                        r_hp    <= '0;
                        r_bit   <= '0;
                    end
                end
                S_SETUP, S_LOW: begin
                    if (w_phase_end) begin
                        r_hp    <= '0;
                        r_sclk  <= 1'b1;
                        r_bit   <= r_bit + 5'd1;
                        r_state <= S_HIGH;
                        if (w_capture) begin
                            r_rx[r_bit[2:0]] <= w_miso_s;
                        end
                    end else begin
                        r_hp <= r_hp + HP_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_hp   <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit == 5'd16) begin
                            r_state <= S_HOLD;
                        end else begin
                            // Next bit goes out on the falling edge so it is
                            // stable for a full half-phase before the rise.
                            r_state <= S_LOW;
                            r_mosi  <= r_sr[14];
                            r_sr    <= {r_sr[13:0], 1'b0};
                        end
                    end else begin
                        r_hp <= r_hp + HP_W'(1);
                    end
                end
                S_HOLD: begin
                    if (w_phase_end) begin
                        r_hp    <= '0;
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= S_GAP;
                    end else begin
                        r_hp <= r_hp + HP_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_phase_end) begin
                        r_hp        <= '0;
                        r_state     <= S_IDLE;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_write ? r_wdata : r_rx;
                    end else begin
                        r_hp <= r_hp + HP_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pwm_host_master.sv
// Bench for spi_pwm_host_master: an H=8 instance talks to a behavioural
// PWM-driver slave, and an H=4 instance is used for phase-timing checks.
module tb_spi_pwm_host_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    spi_pwm_host_master_if ifa ();
    spi_pwm_host_master_if ifb ();

    logic sclk_a, cs_n_a, mosi_a;
    logic miso_a = 1'b0;
    logic sclk_b, cs_n_b, mosi_b;

    spi_pwm_host_master #(.HALF_PERIOD(8), .HP_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .cmd   (ifa.slave),
        .sclk  (sclk_a),
        .cs_n  (cs_n_a),
        .mosi  (mosi_a),
        .miso  (miso_a)
    );

    spi_pwm_host_master #(.HALF_PERIOD(4), .HP_W(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .cmd   (ifb.slave),
        .sclk  (sclk_b),
        .cs_n  (cs_n_b),
        .mosi  (mosi_b),
        .miso  (1'b0)
    );

    // Behavioural slave: shifts mosi in on rises, loads the addressed level
    // after the command byte and shifts it out LSB first on falls, commits
    // writes on fall 16. Raising cs_n abandons a partial frame.
    logic [7:0]  s_regs [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    logic [15:0] s_sr = 16'h0000;
    int          s_cnt = 0;
    logic [7:0]  s_tx = 8'h00;

    always @(posedge sclk_a or negedge cs_n_a) begin
        if (cs_n_a === 1'b0) begin
            if (sclk_a === 1'b1) begin
                s_sr  = {s_sr[14:0], mosi_a};
                s_cnt = s_cnt + 1;
            end else begin
                s_cnt = 0;
            end
        end
    end

    always @(negedge sclk_a) begin
        if (cs_n_a === 1'b0) begin
            if (s_cnt == 8) begin
                s_tx   = s_regs[s_sr[2:0]];
                miso_a = s_tx[0];
            end else if (s_cnt > 8 && s_cnt < 16) begin
                s_tx   = {1'b0, s_tx[7:1]};
                miso_a = s_tx[0];
            end else if (s_cnt == 16 && s_sr[15] == 1'b1) begin
                s_regs[s_sr[10:8]] = s_sr[7:0];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One command on the H=8 instance; returns in the cycle after rsp_valid.
    task automatic run_a(input logic w, input logic [2:0] a, input logic [7:0] d,
                         output logic [7:0] rsp, output int lat, output int rises,
                         output logic [15:0] frame, output logic busy1);
        int n;
        ifa.cmd_write = w;
        ifa.cmd_addr  = a;
        ifa.cmd_data  = d;
        ifa.cmd_valid = 1'b1;
        n = 0;
        while (ifa.cmd_ready !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        chk("ready_wait", n < 100, 1);
        tick;
        busy1         = ifa.busy;
        ifa.cmd_valid = 1'b0;
        ifa.cmd_data  = ~d;
        ifa.cmd_addr  = a ^ 3'd7;
        ifa.cmd_write = ~w;
        lat = 1;
        while (ifa.rsp_valid !== 1'b1 && lat < 400) begin
            tick;
            lat++;
        end
        rsp   = ifa.rsp_data;
        rises = s_cnt;
        frame = s_sr;
        tick;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  a;
        logic [7:0]  d;
        logic [7:0]  exp_rsp;
        logic [15:0] exp_frame;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0]  rsp;
        logic [15:0] frame;
        logic        busy1;
        int          lat, rises, n, hi, cyc, nr, nf, first_low, perr, cnt;
        logic        prev;

        vecs[0] = '{1'b1, 3'd3, 8'hA5, 8'hA5, 16'h83A5};
        vecs[1] = '{1'b0, 3'd3, 8'h00, 8'hA5, 16'h0300};
        vecs[2] = '{1'b1, 3'd0, 8'h00, 8'h00, 16'h8000};
        vecs[3] = '{1'b1, 3'd6, 8'hFF, 8'hFF, 16'h86FF};
        vecs[4] = '{1'b0, 3'd0, 8'h00, 8'h00, 16'h0000};
        vecs[5] = '{1'b0, 3'd6, 8'h00, 8'hFF, 16'h0600};
        vecs[6] = '{1'b1, 3'd0, 8'hFF, 8'hFF, 16'h80FF};
        vecs[7] = '{1'b1, 3'd6, 8'h00, 8'h00, 16'h8600};
        vecs[8] = '{1'b0, 3'd0, 8'h00, 8'hFF, 16'h0000};
        vecs[9] = '{1'b0, 3'd6, 8'h00, 8'h00, 16'h0600};

        reset = 1'b1;
        ifa.cmd_valid = 1'b0; ifa.cmd_write = 1'b0; ifa.cmd_addr = 3'd0; ifa.cmd_data = 8'h00;
        ifb.cmd_valid = 1'b0; ifb.cmd_write = 1'b0; ifb.cmd_addr = 3'd0; ifb.cmd_data = 8'h00;
        repeat (3) tick;

        // Reset state
        chk("rst_cs_n", cs_n_a, 1);
        chk("rst_sclk", sclk_a, 0);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_ready", ifa.cmd_ready, 1);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_rsp_valid", ifa.rsp_valid, 0);
        chk("rst_rsp_data", ifa.rsp_data, 8'h00);
        reset = 1'b0;
        tick;

        // Table-driven single transactions
        for (int i = 0; i < 10; i++) begin
            run_a(vecs[i].w, vecs[i].a, vecs[i].d, rsp, lat, rises, frame, busy1);
            chk($sformatf("v%0d_rsp", i), rsp, vecs[i].exp_rsp);
            chk($sformatf("v%0d_lat", i), lat, 273);
            chk($sformatf("v%0d_rises", i), rises, 16);
            chk($sformatf("v%0d_frame", i), frame, vecs[i].exp_frame);
            chk($sformatf("v%0d_busy", i), busy1, 1);
            chk($sformatf("v%0d_rsp_pulse", i), ifa.rsp_valid, 0);
        end

        chk("reg0", s_regs[0], 8'hFF);
        chk("reg1", s_regs[1], 8'h31);
        chk("reg2", s_regs[2], 8'h32);
        chk("reg3", s_regs[3], 8'hA5);
        chk("reg4", s_regs[4], 8'h34);
        chk("reg5", s_regs[5], 8'h35);
        chk("reg6", s_regs[6], 8'h00);

        // Back-to-back: write addr1=0x5A then read addr1, cmd_valid held high
        ifa.cmd_write = 1'b1; ifa.cmd_addr = 3'd1; ifa.cmd_data = 8'h5A; ifa.cmd_valid = 1'b1;
        n = 0;
        while (ifa.cmd_ready !== 1'b1 && n < 100) begin tick; n++; end
        tick;
        ifa.cmd_write = 1'b0; ifa.cmd_data = 8'h00;
        hi = 0; lat = 1;
        while (ifa.rsp_valid !== 1'b1 && lat < 400) begin
            if (cs_n_a === 1'b1) hi++;
            tick;
            lat++;
        end
        if (cs_n_a === 1'b1) hi++;
        chk("b2b_lat1", lat, 273);
        chk("b2b_rsp1", ifa.rsp_data, 8'h5A);
        chk("b2b_ready_at_rsp", ifa.cmd_ready, 1);
        chk("b2b_cs_high", hi, 9);
        tick;
        ifa.cmd_valid = 1'b0;
        chk("b2b_cs_low_next", cs_n_a, 0);
        chk("b2b_busy_next", ifa.busy, 1);
        lat = 1;
        while (ifa.rsp_valid !== 1'b1 && lat < 400) begin tick; lat++; end
        chk("b2b_lat2", lat, 273);
        chk("b2b_rsp2", ifa.rsp_data, 8'h5A);
        chk("b2b_frame2", s_sr, 16'h0100);
        chk("b2b_reg1", s_regs[1], 8'h5A);
        tick;

        // Reset at fall 5 of a write to addr6
        ifa.cmd_write = 1'b1; ifa.cmd_addr = 3'd6; ifa.cmd_data = 8'h3C; ifa.cmd_valid = 1'b1;
        n = 0;
        while (ifa.cmd_ready !== 1'b1 && n < 100) begin tick; n++; end
        tick;
        ifa.cmd_valid = 1'b0;
        repeat (80) tick;
        chk("abort_sclk_fall5", sclk_a, 0);
        chk("abort_rises", s_cnt, 5);
        chk("abort_mosi_pre", mosi_a, 1);
        reset = 1'b1;
        tick;
        chk("abort_cs_n", cs_n_a, 1);
        chk("abort_sclk", sclk_a, 0);
        chk("abort_mosi", mosi_a, 0);
        chk("abort_ready", ifa.cmd_ready, 1);
        chk("abort_rsp_valid", ifa.rsp_valid, 0);
        chk("abort_rsp_data", ifa.rsp_data, 8'h00);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick;
            if (ifa.rsp_valid === 1'b1) cnt++;
        end
        chk("abort_no_rsp", cnt, 0);
        chk("abort_reg6", s_regs[6], 8'h00);
        run_a(1'b0, 3'd6, 8'h00, rsp, lat, rises, frame, busy1);
        chk("abort_readback", rsp, 8'h00);

        // H=4 instance: ignored pulse during busy, exact phase timing
        ifb.cmd_write = 1'b1; ifb.cmd_addr = 3'd5; ifb.cmd_data = 8'h77; ifb.cmd_valid = 1'b1;
        n = 0;
        while (ifb.cmd_ready !== 1'b1 && n < 100) begin tick; n++; end
        tick;
        ifb.cmd_valid = 1'b0;
        cyc = 1; nr = 0; nf = 0; prev = 1'b0; first_low = -1; perr = 0;
        while (ifb.rsp_valid !== 1'b1 && cyc < 300) begin
            if (cs_n_b === 1'b0 && first_low < 0) first_low = cyc;
            if (sclk_b === 1'b1 && prev === 1'b0) begin
                if (cyc != 1 + (2 * nr + 1) * 4) perr++;
                nr++;
            end
            if (sclk_b === 1'b0 && prev === 1'b1) begin
                if (cyc != 1 + (2 * nf + 2) * 4) perr++;
                nf++;
            end
            prev = sclk_b;
            if (cyc == 20) begin
                ifb.cmd_valid = 1'b1; ifb.cmd_data = 8'h11; ifb.cmd_addr = 3'd2;
            end
            if (cyc == 21) ifb.cmd_valid = 1'b0;
            tick;
            cyc++;
        end
        chk("h4_first_low", first_low, 1);
        chk("h4_frame_len", cyc - first_low, 136);
        chk("h4_rises", nr, 16);
        chk("h4_falls", nf, 16);
        chk("h4_phase_err", perr, 0);
        chk("h4_rsp", ifb.rsp_data, 8'h77);
        tick;
        chk("h4_rsp_pulse", ifb.rsp_valid, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (cs_n_b !== 1'b1) cnt++;
            tick;
        end
        chk("h4_no_second_frame", cnt, 0);
        chk("h4_ready_idle", ifb.cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_pwm_host_master.md
Name: spi_pwm_host_master

Overview:
SPI master that drives the 7-channel SPI PWM driver from another clock domain or chip. It accepts single-register write or read commands on a valid/ready interface and serialises them as two-byte SPI frames. For reads it captures the returned level byte and presents it on a one-cycle response strobe. It pairs with the slave's oversampled SPI front end: SCLK phases are stretched to HALF_PERIOD clk cycles so the slave's own clock can see every edge.

Parameters:
HALF_PERIOD, 8, clk cycles per SCLK half-phase. Legal minimum is 4. Each half-phase in time must cover at least 3 slave clk periods.
HP_W, 8, width of the half-period counter. Must satisfy HALF_PERIOD < 2**HP_W.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  master idle; command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  3  PWM channel index, 0..6
cmd_data  input  8  level to write; ignored for reads
rsp_valid  output  1  one-cycle pulse on transaction completion
rsp_data  output  8  read: level returned by slave; write: cmd_data echoed
busy  output  1  equals !cmd_ready
sclk  output  1  SPI clock, idles low
cs_n  output  1  chip select, active-low, idles high
mosi  output  1  serial data to slave, MSB first
miso  input  1  serial data from slave, LSB first; asynchronous, passed through a 2-FF synchroniser (miso_s)

Behaviour:
- Reset values (applied on the first clk edge with reset=1, from any state):
  - cs_n=1, sclk=0, mosi=0.
  - cmd_ready=1, rsp_valid=0, rsp_data=0.
  - State IDLE; counters 0; synchroniser flops 0.
- Reset mid-frame aborts the frame with no rsp_valid. Raising cs_n clears the slave's SPI state, so a partial frame writes nothing.
- Frame is 16 bits, shift register sr[15:0], shifted out MSB first:
  - Write: sr = {1'b1, 4'b0000, cmd_addr, cmd_data}.
  - Read: sr = {1'b0, 4'b0000, cmd_addr, 8'h00}.
  - cmd_write, cmd_addr and cmd_data are latched on acceptance. Later input changes have no effect.
- State machine: IDLE -> SETUP -> HIGH/LOW x16 -> HOLD -> GAP -> IDLE. H = HALF_PERIOD. T = acceptance cycle.
  - IDLE: cmd_ready=1. On acceptance, cmd_ready=0 from T+1.
  - SETUP: from T+1, cs_n=0 and mosi=sr[15]. Lasts H cycles.
  - Rise k (k=1..16) occurs at T+1+(2k-1)H; sclk=1 for H cycles.
  - Fall k occurs at T+1+2kH; sclk=0. For k<16, mosi changes to the next bit in the same cycle. mosi is stable across each rise.
  - HOLD: after fall 16, cs_n stays 0 and sclk stays 0 for H cycles. This lets the slave act on the final falling edge, which is where it commits the write.
  - GAP: cs_n=1 from T+1+33H, mosi=0, for H cycles.
  - IDLE re-entry at T+1+34H: rsp_valid=1 for exactly that cycle, cmd_ready=1 in the same cycle.
  - Total frame: 34H cycles from first cs_n low to rsp_valid.
- Read capture:
  - In the cycle each rise k=9..16 is issued, rsp_data[k-9] <= miso_s.
  - The slave loads the level after the command byte and shifts it right on each falling edge. Bit0 is therefore captured at rise 9 and bit7 at rise 16.
- Write response: rsp_data <= latched cmd_data at rsp_valid.
- rsp_data holds its value until the next rsp_valid.
- Back-to-back: a command presented in the rsp_valid cycle is accepted in that cycle. The next cs_n falls 1 cycle later. Minimum cs_n-high gap is therefore H+1 cycles.
- cmd_valid while busy is ignored; no queueing.
- cmd_addr=7 is transmitted unchanged. The returned read data is undefined, and no error is flagged.
- Half-period counter counts 0..H-1 and wraps on each phase boundary. Bit counter is 0..16, 5 bits.

Test Plan:
- H=8, write addr 3 = 0xA5 into a behavioural slave model. Required: mosi bits 0x83 then 0xA5 sampled at sclk rises; exactly 16 rises; slave reg3=0xA5; rsp_valid at T+1+272 with rsp_data=0xA5.
- Read addr 3 after the write. Required: mosi 0x03 then 0x00; rsp_data=0xA5; slave registers unchanged.
- Write/read boundary data 0x00 and 0xFF on addr 0 and addr 6. Required: read-back matches each value; other channels unchanged.
- Back-to-back write addr 1 = 0x5A then read addr 1, with cmd_valid held high. Required: second acceptance in the rsp_valid cycle; cs_n high for exactly 9 cycles; second rsp_data=0x5A.
- Assert reset at fall 5 of a write frame. Required: next cycle cs_n=1, sclk=0, mosi=0, cmd_ready=1; no rsp_valid; slave register unchanged.
- H=4, pulse cmd_valid during busy. Required: pulse ignored; frame length 136 cycles; sclk high/low phases exactly 4 cycles each.
